// File: rtl/xor_fitness_evaluator.sv
// Drives spiking_neural_network_xor through the four XOR patterns and scores each answer.
// Optional per-pattern wait timeout is built when XOR_FITNESS_TIMEOUT_EN is defined.
module xor_fitness_evaluator #(
  parameter int CMD_WIDTH = 3,
  parameter int ADDR_WIDTH = 3,
  parameter logic [CMD_WIDTH-1:0] CMD_CLEAR = CMD_WIDTH'((32'd1 << CMD_WIDTH) - 32'd3),
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            fitness,
  output logic [3:0]            result_mask,
  output logic [3:0]            timeout_mask,
  output logic [ADDR_WIDTH-1:0] net_addr,
  output logic [CMD_WIDTH-1:0]  net_cmd,
  output logic [1:0]            net_in,
  input  logic                  net_out_valid,
  input  logic                  net_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("xor_fitness_evaluator: TIMEOUT_CYCLES must be 1..65535");
  end

  function automatic logic [1:0] pattern_of(input logic [1:0] idx);
    logic [1:0] pat;
    case (idx)
      2'd0:    pat = 2'b00;
      2'd1:    pat = 2'b11;
      2'd2:    pat = 2'b01;
      2'd3:    pat = 2'b10;
      default: pat = 2'b00;
    endcase
    return pat;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  res_acc_q, res_acc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  fitness_q, fitness_d;
  logic [3:0]  result_mask_q, result_mask_d;
  logic [CMD_WIDTH-1:0] net_cmd_q, net_cmd_d;
  logic [1:0]  net_in_q, net_in_d;
  logic        pattern_end_s;
  logic        correct_s;

`ifdef XOR_FITNESS_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  to_acc_q, to_acc_d;
  logic [3:0]  timeout_mask_q, timeout_mask_d;
  logic        timed_out_s;
`endif

  // Next-state, pattern scoring and accumulator update
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    res_acc_d     = res_acc_q;
    pattern_end_s = 1'b0;
    correct_s     = 1'b0;
`ifdef XOR_FITNESS_TIMEOUT_EN
    cnt_d         = cnt_q;
    to_acc_d      = to_acc_q;
    timed_out_s   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_APPLY;
          idx_d     = 2'd0;
          res_acc_d = 4'b0000;
`ifdef XOR_FITNESS_TIMEOUT_EN
          to_acc_d  = 4'b0000;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_APPLY: begin
        state_d = S_WAIT;
`ifdef XOR_FITNESS_TIMEOUT_EN
        cnt_d   = 16'd0;
`endif
      end
      S_WAIT: begin
        // A valid answer wins over a timeout landing in the same cycle.
        if (net_out_valid) begin
          pattern_end_s = 1'b1;
          correct_s     = (net_out == (^pattern_of(idx_q)));
`ifdef XOR_FITNESS_TIMEOUT_EN
        end else if (cnt_q >= TO_LAST) begin
          pattern_end_s = 1'b1;
          timed_out_s   = 1'b1;
        end else begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`endif
        end else begin
          pattern_end_s = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pattern_end_s) begin
      res_acc_d[idx_q] = correct_s;
`ifdef XOR_FITNESS_TIMEOUT_EN
      to_acc_d[idx_q]  = timed_out_s;
`endif
      if (idx_q == 2'd3) begin
        state_d = S_DONE;
      end else begin
        state_d = S_APPLY;
        idx_d   = idx_q + 2'd1;
      end
    end else begin
      idx_d = idx_d;
    end
  end

  // Registered outputs, computed from the upcoming state
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    net_cmd_d     = (state_d == S_APPLY) ? CMD_CLEAR : {CMD_WIDTH{1'b0}};
    net_in_d      = net_in_q;
    fitness_d     = fitness_q;
    result_mask_d = result_mask_q;
`ifdef XOR_FITNESS_TIMEOUT_EN
    timeout_mask_d = timeout_mask_q;
`endif
    if (state_d == S_APPLY) begin
      net_in_d = pattern_of(idx_d);
    end else begin
      net_in_d = net_in_q;
    end
    if (state_d == S_DONE) begin
      fitness_d      = popcount4(res_acc_d);
      result_mask_d  = res_acc_d;
`ifdef XOR_FITNESS_TIMEOUT_EN
      timeout_mask_d = to_acc_d;
`endif
    end else begin
      fitness_d = fitness_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= 2'd0;
      res_acc_q     <= 4'b0000;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fitness_q     <= 3'd0;
      result_mask_q <= 4'b0000;
      net_cmd_q     <= {CMD_WIDTH{1'b0}};
      net_in_q      <= 2'b00;
`ifdef XOR_FITNESS_TIMEOUT_EN
      cnt_q          <= 16'd0;
      to_acc_q       <= 4'b0000;
      timeout_mask_q <= 4'b0000;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      res_acc_q     <= res_acc_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fitness_q     <= fitness_d;
      result_mask_q <= result_mask_d;
      net_cmd_q     <= net_cmd_d;
      net_in_q      <= net_in_d;
`ifdef XOR_FITNESS_TIMEOUT_EN
      cnt_q          <= cnt_d;
      to_acc_q       <= to_acc_d;
      timeout_mask_q <= timeout_mask_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign fitness     = fitness_q;
  assign result_mask = result_mask_q;
  assign net_addr    = {ADDR_WIDTH{1'b1}};
  assign net_cmd     = net_cmd_q;
  assign net_in      = net_in_q;
`ifdef XOR_FITNESS_TIMEOUT_EN
  assign timeout_mask = timeout_mask_q;
`else
  assign timeout_mask = 4'b0000;
`endif

endmodule

// File: doc/xor_fitness_evaluator.md
# xor_fitness_evaluator

Hardware replacement for the fitness loop the annealing bench currently runs in simulation. It sits directly upstream of `spiking_neural_network_xor`. On `start` it drives the network through the four XOR input patterns, issuing a broadcast clear before each one. It waits for each answer, scores it against the expected XOR value and reports a 0..4 fitness to the annealing controller.

## Interface

Parameters:
- `CMD_WIDTH`, 3: network command width.
- `ADDR_WIDTH`, 3: network address width.
- `CMD_CLEAR`, `(1<<CMD_WIDTH)-3`: network clear opcode.
- `TIMEOUT_CYCLES`, 1023: maximum wait cycles per pattern. Range 1..65535.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin an evaluation; honoured only in IDLE.
- `busy`  out  1: high from start acceptance until DONE is left.
- `done`  out  1: one-cycle pulse in the DONE state.
- `fitness`  out  3: number of correct patterns, 0..4.
- `result_mask`  out  4: bit i set when pattern i was answered correctly.
- `timeout_mask`  out  4: bit i set when pattern i timed out.
- `net_addr`  out  ADDR_WIDTH: always all-ones (broadcast).
- `net_cmd`  out  CMD_WIDTH: `CMD_CLEAR` in APPLY, 0 otherwise.
- `net_in`  out  2: current pattern `{in1,in2}`.
- `net_out_valid`  in  1: network answer valid.
- `net_out`  in  1: network answer; must be 0 or 1 while valid.

## Operation

- Pattern order i = 0..3: 00, 11, 01, 10. Expected outputs: 0, 0, 1, 1.
- States and transitions:
  - IDLE: `start` → APPLY, with pattern index 0 and the internal accumulators cleared.
  - APPLY: one cycle. `net_in` = pattern, `net_cmd` = `CMD_CLEAR`, wait counter set to 0. → WAIT.
  - WAIT: `net_cmd` = 0 and `net_in` held.
    - `net_out_valid`: record `net_out == expected`, then go to APPLY for the next pattern, or to DONE after pattern 3.
    - No valid: the counter increments. When the counter reaches `TIMEOUT_CYCLES` the pattern is scored wrong, its timeout bit is set, and the FSM advances as above.
  - DONE: one cycle. `done` = 1. `fitness`, `result_mask` and `timeout_mask` load from the accumulators. → IDLE.
- `net_out_valid` is ignored outside WAIT, including during APPLY, so a stale answer from the previous pattern is never scored.
- `net_in` holds its last pattern in IDLE and DONE.
- Reporting outputs change only on DONE entry. They hold until the next DONE, or until reset.
- Arithmetic:
  - `fitness` equals the popcount of `result_mask`.
  - The wait counter is 16 bits and saturates; it never wraps.

## Timing

- Reset values: `busy` 0, `done` 0, `fitness` 0, `result_mask` 0, `timeout_mask` 0, `net_cmd` 0, `net_in` 00, `net_addr` all-ones, state IDLE.
- Reset asserted mid-run aborts immediately, with no `done` pulse.
- With `start` sampled at cycle 0:
  - APPLY of pattern 0 is cycle 1 and `busy` rises in cycle 1.
  - Each pattern takes 1 + w cycles, where w ≥ 1 is the number of WAIT cycles including the valid cycle.
  - Minimum latency: DONE in cycle 9.
  - Worst case, all patterns timing out: DONE in cycle 1 + 4·(1+`TIMEOUT_CYCLES`).
- If valid and timeout coincide, valid wins and the answer is scored.
- `start` while busy, or in the DONE cycle, is ignored; it is not queued.
- `busy` falls in the cycle after DONE.

## Configuration

- `XOR_FITNESS_TIMEOUT_EN` defined:
  - The wait counter and timeout path are present.
  - `timeout_mask` reports timeouts as described above.
- `XOR_FITNESS_TIMEOUT_EN` undefined:
  - No counter is present; WAIT holds until `net_out_valid` indefinitely.
  - `timeout_mask` is tied to 0.
  - The `TIMEOUT_CYCLES` parameter is ignored.

## Test plan

- Ideal XOR model (valid one cycle after clear, `out = a^b`), start at cycle 0 → `done` in cycle 9, `fitness` = 4, `result_mask` = 1111, `timeout_mask` = 0000.
- Model answering constant 0 with valid after 5 cycles → `fitness` = 2, `result_mask` = 0011, one clear per pattern with `net_addr` = 111, `net_cmd` = 5.
- `XOR_FITNESS_TIMEOUT_EN` defined, `TIMEOUT_CYCLES` = 16, model never valid → `done` in cycle 69, `fitness` = 0, `timeout_mask` = 1111.
- Model holds valid high with the correct answer through APPLY → the APPLY cycle is not scored, the WAIT cycle is, and `fitness` = 4; a second `start` pulsed during WAIT produces only one `done`.
- `rst` low during WAIT of pattern 2 → outputs return to reset values within the same cycle, no `done`; the next `start` runs a full evaluation with `fitness` = 4.
- Valid arrives on exactly the 16th WAIT cycle with `TIMEOUT_CYCLES` = 16 → scored correct, `timeout_mask` bit clear.
